loop_filter: RTL
================

Name: loop_filter

Overview:
- Proportional-plus-integral loop filter for the carrier/symbol tracking loops.
- Consumes the signed phase/timing error from the discriminator and the configuration outputs of the loop-filter register block: invertError, zeroError, slip, lead, lag, limit, loopOffset.
- Produces a 32-bit two's-complement frequency control word for the NCO.
- Lead and lag are power-of-two gains; the integrator is bounded by ±limit.

Parameters:
- ERR_WIDTH, 8, width of signed error input.
- ACC_WIDTH, 32, width of integrator and output word.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- clkEn  input  1  global clock enable; all state holds when low.
- error  input  ERR_WIDTH  signed discriminator error.
- errorValid  input  1  error qualifier, single-cycle strobe.
- invertError  input  1  negate error.
- zeroError  input  1  force error to zero (opens loop).
- slip  input  1  wrap integrator at limit instead of clamping.
- lead  input  5  proportional gain, left-shift count 0..31.
- lag  input  5  integral gain, left-shift count 0..31.
- limit  input  32  integrator magnitude bound; bit 31 ignored.
- loopOffset  input  32  signed constant added to output (centre frequency).
- freqOut  output  ACC_WIDTH  signed frequency word.
- freqValid  output  1  freqOut qualifier.
- integrator  output  ACC_WIDTH  current integrator value, for status readback.

Behaviour:
- Config inputs are written from the bus-strobe domain. They are registered once into clk at the start of every pipeline pass. Software changes gains only while zeroError=1.
- Reset values: freqOut=0, freqValid=0, integrator=0, all pipeline registers 0.
- Pipeline (advances only when clkEn=1):
  - S1, on errorValid: e = zeroError ? 0 : (invertError ? -error : error).
  - S1 saturation: -(-128) saturates to +127.
  - S2, lead term: leadTerm = sign-extend(e) << lead, computed at ERR_WIDTH+31 bits, saturated to ACC_WIDTH.
  - S2, lag term: lagTerm computed the same way using lag.
  - S2, integrator: sum = integrator + lagTerm at ACC_WIDTH+1 bits. Bound L = {1'b0, limit[30:0]}.
  - If sum > L: slip=0 gives integrator=L; slip=1 gives integrator = sum - 2L (wraps to the negative side).
  - If sum < -L: slip=0 gives integrator=-L; slip=1 gives integrator = sum + 2L.
  - Otherwise integrator=sum.
  - Wrap correction is a single subtraction or addition; lagTerm > 2L is additionally clamped.
  - S3: freqOut = sat32(integrator + leadTerm + loopOffset), computed at ACC_WIDTH+2 bits.
- freqValid pulses for 1 clkEn-cycle. Latency is exactly 3 enabled cycles after errorValid.
- Back-to-back errorValid every cycle is supported at full throughput.
- limit=0: integrator is held at 0 (pure proportional loop); slip has no effect.
- zeroError=1: the integrator holds its value; freqOut = integrator + loopOffset.
- Reset mid-pipeline: all in-flight samples are discarded and no freqValid is emitted.
- clkEn=0 with errorValid=1: the sample is ignored.

Optional Feature:
- Macro: LF_LIMIT_STATUS_EN.
- With the macro: adds outputs upperHit, lowerHit (1 bit each, sticky) and slipCount (8 bits, wraps 255→0).
  - upperHit/lowerHit set when a clamp or wrap occurs at the matching bound.
  - slipCount increments on each wrap.
  - New input clearStatus (1 bit) clears all three in one cycle; a simultaneous hit takes priority and leaves the status set.
  - All reset to 0.
- Without the macro: these ports and the logic behind them are absent; the datapath is identical.

Decomposition:
- Shared include file lfDefines.v holds:
  - ERR_WIDTH and ACC_WIDTH defaults.
  - Saturation constants MAX_POS32 and MAX_NEG32.
  - Shift-intermediate width (ERR_WIDTH+31).
- One sub-module, lf_sat_shift: combinational sign-extend, shift, and saturate, instantiated twice (lead and lag).
- All state stays in loop_filter.

Test Plan:
- Reset, then error=+4, lead=2, lag=0, limit=100, loopOffset=0x1000, errorValid once → 3 cycles later freqValid=1, freqOut=0x1000+4+16=0x1014, integrator=4.
- error=+127, lag=4, limit=1000, slip=0, 10 strobes → integrator runs 2032 then clamps, holding 1000 from strobe 1 on; negative input clamps at -1000.
- Same as previous with slip=1, limit=3000, single strobe from integrator=2000 → sum 4032 → integrator=-1968.
- error=-128, invertError=1, lead=0, lag=0 → effective error +127; zeroError=1 → integrator frozen and freqOut=integrator+loopOffset.
- lead=31, error=+1, loopOffset=0x7FFFFFFF → freqOut saturates to 0x7FFFFFFF, no wrap; reset asserted 1 cycle after errorValid → no freqValid.
- LF_LIMIT_STATUS_EN: force 3 upper wraps → upperHit=1, slipCount=3; clearStatus pulse → all 0.

Source files
------------

// File: rtl/loop_filter_pkg.sv
// +----------------------------------------------------------------------+
// | loop_filter_pkg : shared widths and saturation constants             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package loop_filter_pkg;
  localparam int          LF_ERR_WIDTH       = 8;
  localparam int          LF_ACC_WIDTH       = 32;
  localparam int          LF_SHIFT_HEADROOM  = 31;
  localparam int          LF_SHIFT_WIDTH     = LF_ERR_WIDTH + LF_SHIFT_HEADROOM;
  localparam logic [31:0] MAX_POS32          = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_NEG32          = 32'h8000_0000;
endpackage

`default_nettype wire

// File: rtl/loop_filter_if.sv
// +----------------------------------------------------------------------+
// | loop_filter_if : error-in / frequency-out handshake bundle           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface loop_filter_if
  import loop_filter_pkg::*;
#(
  parameter int ERR_WIDTH = LF_ERR_WIDTH,
  parameter int ACC_WIDTH = LF_ACC_WIDTH
);
  logic signed [ERR_WIDTH-1:0] error;
  logic                        errorValid;
  logic signed [ACC_WIDTH-1:0] freqOut;
  logic                        freqValid;
  logic signed [ACC_WIDTH-1:0] integrator;

  modport master (output error, errorValid, input freqOut, freqValid, integrator);
  modport slave  (input error, errorValid, output freqOut, freqValid, integrator);
endinterface

`default_nettype wire

// File: rtl/lf_sat_shift.sv
// +----------------------------------------------------------------------+
// | lf_sat_shift : sign-extend, power-of-two gain shift, saturate        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lf_sat_shift
  import loop_filter_pkg::*;
#(
  parameter int ERR_WIDTH = LF_ERR_WIDTH,
  parameter int ACC_WIDTH = LF_ACC_WIDTH
) (
  input  wire logic signed [ERR_WIDTH-1:0] i_err,
  input  wire logic        [4:0]           i_shift,
  output logic      signed [ACC_WIDTH-1:0] o_term
);
  localparam int SW = ERR_WIDTH + LF_SHIFT_HEADROOM;
  localparam logic signed [SW-1:0] c_max = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] c_min = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic signed [SW-1:0] w_ext;
  logic signed [SW-1:0] w_shifted;

  // Headroom of 31 bits means even a full-scale error shifted by 31 cannot overflow.
  assign w_ext     = {{LF_SHIFT_HEADROOM{i_err[ERR_WIDTH-1]}}, i_err};
  assign w_shifted = w_ext <<< i_shift;

  always_comb begin
    o_term = w_shifted[ACC_WIDTH-1:0];
    if (w_shifted > c_max)      o_term = c_max[ACC_WIDTH-1:0];
    else if (w_shifted < c_min) o_term = c_min[ACC_WIDTH-1:0];
  end
endmodule

`default_nettype wire

// File: rtl/loop_filter.sv
// +----------------------------------------------------------------------+
// | loop_filter : 3-stage PI loop filter producing an NCO frequency word |
// | Optional limit status outputs: define LF_LIMIT_STATUS_EN. Rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module loop_filter
  import loop_filter_pkg::*;
#(
  parameter int ERR_WIDTH = LF_ERR_WIDTH,
  parameter int ACC_WIDTH = LF_ACC_WIDTH
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clkEn,
  loop_filter_if.slave     bus,
  input  wire logic        invertError,
  input  wire logic        zeroError,
  input  wire logic        slip,
  input  wire logic [4:0]  lead,
  input  wire logic [4:0]  lag,
  input  wire logic [31:0] limit,
  input  wire logic [31:0] loopOffset
`ifdef LF_LIMIT_STATUS_EN
  ,
  input  wire logic        clearStatus,
  output logic             upperHit,
  output logic             lowerHit,
  output logic [7:0]       slipCount
`endif
);
  localparam int W  = ACC_WIDTH + 3;
  localparam int TW = ACC_WIDTH + 2;
  localparam logic signed [ERR_WIDTH-1:0] c_err_max = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] c_err_min = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic signed [TW-1:0]        c_pos_t   = TW'(signed'(MAX_POS32));
  localparam logic signed [TW-1:0]        c_neg_t   = TW'(signed'(MAX_NEG32));

  logic signed [ERR_WIDTH-1:0] w_neg, w_e;
  logic signed [ERR_WIDTH-1:0] r1_e;
  logic        [4:0]           r1_lead, r1_lag;
  logic        [30:0]          r1_limit;
  logic                        r1_slip, r1_valid;
  logic signed [31:0]          r1_offset;
  logic signed [ACC_WIDTH-1:0] w_leadTerm, w_lagTerm;
  logic signed [ACC_WIDTH-1:0] r_integrator, r2_lead;
  logic signed [31:0]          r2_offset;
  logic                        r2_valid;
  logic signed [W-1:0]         w_sum, w_L, w_next;
  logic                        w_upper, w_lower, w_wrap;
  logic signed [TW-1:0]        w_total;
  logic signed [ACC_WIDTH-1:0] w_sat, r_freqOut;
  logic                        r_freqValid;
  wire                         w_unused_limit_msb = limit[31];

  // S1: negating the most negative error would overflow, so pin it to full scale.
  assign w_neg = (bus.error == c_err_min) ? c_err_max : -bus.error;
  assign w_e   = zeroError ? '0 : (invertError ? w_neg : bus.error);

  lf_sat_shift #(.ERR_WIDTH(ERR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lead (
    .i_err(r1_e), .i_shift(r1_lead), .o_term(w_leadTerm));
  lf_sat_shift #(.ERR_WIDTH(ERR_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lag (
    .i_err(r1_e), .i_shift(r1_lag), .o_term(w_lagTerm));

  assign w_sum = W'(r_integrator) + W'(w_lagTerm);
  assign w_L   = W'(r1_limit);

  // S2 bound: wrap moves by one full span 2L; anything still outside is clamped.
  always_comb begin
    w_next  = w_sum;
    w_upper = 1'b0;
    w_lower = 1'b0;
    w_wrap  = 1'b0;
    if (w_L == '0) begin
      w_next = '0;
    end else if (w_sum > w_L) begin
      w_upper = 1'b1;
      w_wrap  = r1_slip;
      w_next  = r1_slip ? (w_sum - (w_L + w_L)) : w_L;
      if (w_next > w_L) w_next = w_L;
    end else if (w_sum < -w_L) begin
      w_lower = 1'b1;
      w_wrap  = r1_slip;
      w_next  = r1_slip ? (w_sum + (w_L + w_L)) : -w_L;
      if (w_next < -w_L) w_next = -w_L;
    end
  end

  assign w_total = TW'(r_integrator) + TW'(r2_lead) + TW'(r2_offset);

  always_comb begin
    w_sat = w_total[ACC_WIDTH-1:0];
    if (w_total > c_pos_t)      w_sat = ACC_WIDTH'(MAX_POS32);
    else if (w_total < c_neg_t) w_sat = ACC_WIDTH'(MAX_NEG32);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_e         <= '0;
      r1_lead      <= '0;
      r1_lag       <= '0;
      r1_limit     <= '0;
      r1_slip      <= 1'b0;
      r1_offset    <= '0;
      r1_valid     <= 1'b0;
      r_integrator <= '0;
      r2_lead      <= '0;
      r2_offset    <= '0;
      r2_valid     <= 1'b0;
      r_freqOut    <= '0;
      r_freqValid  <= 1'b0;
    end else if (clkEn) begin
      r1_valid    <= bus.errorValid;
      r2_valid    <= r1_valid;
      r_freqValid <= r2_valid;
      if (bus.errorValid) begin
        r1_e      <= w_e;
        r1_lead   <= lead;
        r1_lag    <= lag;
        r1_limit  <= limit[30:0];
        r1_slip   <= slip;
        r1_offset <= loopOffset;
      end
      if (r1_valid) begin
        r_integrator <= w_next[ACC_WIDTH-1:0];
        r2_lead      <= w_leadTerm;
        r2_offset    <= r1_offset;
      end
      if (r2_valid) r_freqOut <= w_sat;
    end
  end

  assign bus.freqOut    = r_freqOut;
  assign bus.freqValid  = r_freqValid;
  assign bus.integrator = r_integrator;

`ifdef LF_LIMIT_STATUS_EN
  logic       r_upperHit, r_lowerHit;
  logic [7:0] r_slipCount;

  // A hit in the same cycle as clearStatus wins, leaving the status set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upperHit  <= 1'b0;
      r_lowerHit  <= 1'b0;
      r_slipCount <= '0;
    end else if (clkEn) begin
      r_upperHit  <= (clearStatus ? 1'b0 : r_upperHit) | (r1_valid & w_upper);
      r_lowerHit  <= (clearStatus ? 1'b0 : r_lowerHit) | (r1_valid & w_lower);
      r_slipCount <= (clearStatus ? 8'd0 : r_slipCount) + {7'd0, r1_valid & w_wrap};
    end
  end

  assign upperHit  = r_upperHit;
  assign lowerHit  = r_lowerHit;
  assign slipCount = r_slipCount;
`else
  wire w_unused_status = w_upper ^ w_lower ^ w_wrap;
`endif
endmodule

`default_nettype wire
